// File: rtl/operand_stack.sv
// Operand stack with registered top/next-on-stack views and sticky fault trap.
// Entries live in a flat array; tos/nos are kept in flops so reads never wait on memory.
module operand_stack #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic [2:0]       trap
);

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_BINOP = 3'd3,
        OP_UNOP  = 3'd4,
        OP_CLEAR = 3'd5
    } op_e;

    localparam logic [2:0] TRAP_NONE  = 3'd0;
    localparam logic [2:0] TRAP_OVER  = 3'd1;
    localparam logic [2:0] TRAP_UNDER = 3'd2;
    localparam logic [2:0] TRAP_ILL   = 3'd3;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic [2:0]       trap_q, trap_d;
    logic             ready_q, ready_d;

    logic             accept;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [CW-1:0]    idx1, idx2, idx3;
    logic [WIDTH-1:0] below_nos;

    assign idx1 = count_q - CW'(1);
    assign idx2 = count_q - CW'(2);
    assign idx3 = count_q - CW'(3);

    // Entry that becomes nos when two slots drop off the top view.
    assign below_nos = (count_q >= CW'(3)) ? mem[idx3[AW-1:0]] : '0;

    // Next-state decode for one accepted op; faults leave all state untouched.
    always_comb begin
        accept  = op_valid && ready_q;
        count_d = count_q;
        tos_d   = tos_q;
        nos_d   = nos_q;
        trap_d  = trap_q;
        we      = 1'b0;
        waddr   = count_q[AW-1:0];
        if (accept) begin
            unique case (op)
                OP_NOP: ;
                OP_PUSH: begin
                    if (count_q == CW'(DEPTH)) begin
                        trap_d = TRAP_OVER;
                    end else begin
                        we      = 1'b1;
                        waddr   = count_q[AW-1:0];
                        count_d = count_q + CW'(1);
                        nos_d   = tos_q;
                        tos_d   = wr_data;
                    end
                end
                OP_POP: begin
                    if (count_q == '0) begin
                        trap_d = TRAP_UNDER;
                    end else begin
                        count_d = idx1;
                        tos_d   = nos_q;
                        nos_d   = below_nos;
                    end
                end
                OP_BINOP: begin
                    if (count_q < CW'(2)) begin
                        trap_d = TRAP_UNDER;
                    end else begin
                        we      = 1'b1;
                        waddr   = idx2[AW-1:0];
                        count_d = idx1;
                        tos_d   = wr_data;
                        nos_d   = below_nos;
                    end
                end
                OP_UNOP: begin
                    if (count_q == '0) begin
                        trap_d = TRAP_UNDER;
                    end else begin
                        we    = 1'b1;
                        waddr = idx1[AW-1:0];
                        tos_d = wr_data;
                    end
                end
                OP_CLEAR: begin
                    count_d = '0;
                    tos_d   = '0;
                    nos_d   = '0;
                end
                default: trap_d = TRAP_ILL;
            endcase
        end
        ready_d = (trap_d == TRAP_NONE);
    end

    // Control and view registers; ready rises on the first edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tos_q   <= '0;
            nos_q   <= '0;
            trap_q  <= TRAP_NONE;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            trap_q  <= trap_d;
            ready_q <= ready_d;
        end
    end

    // Entry storage; stale contents are harmless since count bounds every read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wr_data;
        end
    end

    assign op_ready = ready_q;
    assign tos      = tos_q;
    assign nos      = nos_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign trap     = trap_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed-vector bench for operand_stack.
// Each op is driven just after a rising edge and checked just after the next.
module tb_operand_stack;

    localparam int WIDTH = 64;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] PUSH  = 3'd1;
    localparam logic [2:0] POP   = 3'd2;
    localparam logic [2:0] BINOP = 3'd3;
    localparam logic [2:0] UNOP  = 3'd4;
    localparam logic [2:0] CLEAR = 3'd5;

    logic             clk;
    logic             reset;
    logic [2:0]       op;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             empty;
    logic [2:0]       trap;

    int n_vec;
    int n_err;

    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .wr_data  (wr_data),
        .tos      (tos),
        .nos      (nos),
        .count    (count),
        .empty    (empty),
        .trap     (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [2:0] o, input logic [WIDTH-1:0] d);
        op       = o;
        wr_data  = d;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = NOP;
    endtask

    task automatic view(input string tag, input logic [WIDTH-1:0] et,
                        input logic [WIDTH-1:0] en, input int ec,
                        input logic [2:0] etr);
        chk({tag, ".tos"}, tos, et);
        chk({tag, ".nos"}, nos, en);
        chk({tag, ".count"}, 64'(count), 64'(ec));
        chk({tag, ".empty"}, 64'(empty), 64'(ec == 0));
        chk({tag, ".trap"}, 64'(trap), 64'(etr));
        chk({tag, ".ready"}, 64'(op_ready), 64'(etr == 3'd0));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b0;
        op       = NOP;
        op_valid = 1'b0;
        wr_data  = '0;
        #12;
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.empty", 64'(empty), 64'd1);
        chk("rst.tos", tos, 64'd0);
        chk("rst.nos", nos, 64'd0);
        chk("rst.trap", 64'(trap), 64'd0);
        chk("rst.ready", 64'(op_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel.ready", 64'(op_ready), 64'd1);

        apply(PUSH, 64'd5);
        apply(PUSH, 64'd5);
        apply(BINOP, 64'd0);
        view("v032", 64'd0, 64'd0, 1, 3'd0);
        apply(CLEAR, 64'd0);
        view("clr1", 64'd0, 64'd0, 0, 3'd0);

        apply(PUSH, 64'd1);
        apply(PUSH, 64'd2);
        view("v033a", 64'd2, 64'd1, 2, 3'd0);
        apply(BINOP, 64'd1);
        view("v033", 64'd1, 64'd0, 1, 3'd0);
        apply(CLEAR, 64'd0);

        apply(PUSH, 64'd10);
        apply(PUSH, 64'd20);
        apply(PUSH, 64'd30);
        apply(PUSH, 64'd40);
        view("p4", 64'd40, 64'd30, 4, 3'd0);
        apply(BINOP, 64'd99);
        view("bin4", 64'd99, 64'd20, 3, 3'd0);
        apply(POP, 64'd0);
        view("pop3", 64'd20, 64'd10, 2, 3'd0);
        apply(NOP, 64'd77);
        view("nop", 64'd20, 64'd10, 2, 3'd0);
        op      = PUSH;
        wr_data = 64'd55;
        @(posedge clk);
        #1;
        op = NOP;
        view("noval", 64'd20, 64'd10, 2, 3'd0);
        apply(POP, 64'd0);
        apply(POP, 64'd0);
        view("pop0", 64'd0, 64'd0, 0, 3'd0);

        apply(PUSH, 64'hFFFF_FFFF_FFFF_FFFF);
        view("allf", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 3'd0);
        apply(UNOP, 64'h8000_0000_0000_0000);
        view("v034", 64'h8000_0000_0000_0000, 64'd0, 1, 3'd0);
        apply(BINOP, 64'd3);
        view("binund", 64'h8000_0000_0000_0000, 64'd0, 1, 3'd2);
        do_reset();
        view("rst2", 64'd0, 64'd0, 0, 3'd0);

        for (int i = 1; i <= DEPTH; i++) begin
            apply(PUSH, 64'(i) * 64'h0101_0000_0000_0001);
        end
        view("full", 64'(DEPTH) * 64'h0101_0000_0000_0001,
             64'(DEPTH - 1) * 64'h0101_0000_0000_0001, DEPTH, 3'd0);
        apply(PUSH, 64'hDEAD);
        view("v035", 64'(DEPTH) * 64'h0101_0000_0000_0001,
             64'(DEPTH - 1) * 64'h0101_0000_0000_0001, DEPTH, 3'd1);
        apply(POP, 64'd0);
        view("stick1", 64'(DEPTH) * 64'h0101_0000_0000_0001,
             64'(DEPTH - 1) * 64'h0101_0000_0000_0001, DEPTH, 3'd1);
        do_reset();

        apply(POP, 64'd0);
        view("v036", 64'd0, 64'd0, 0, 3'd2);
        apply(PUSH, 64'd9);
        view("v036b", 64'd0, 64'd0, 0, 3'd2);
        do_reset();

        apply(UNOP, 64'd1);
        view("unund", 64'd0, 64'd0, 0, 3'd2);
        do_reset();

        apply(PUSH, 64'd4);
        apply(3'd6, 64'd8);
        view("ill6", 64'd4, 64'd0, 1, 3'd3);
        do_reset();
        apply(3'd7, 64'd8);
        view("ill7", 64'd0, 64'd0, 0, 3'd3);
        do_reset();

        apply(PUSH, 64'd11);
        apply(PUSH, 64'd12);
        apply(PUSH, 64'd13);
        op       = PUSH;
        wr_data  = 64'd14;
        op_valid = 1'b1;
        reset    = 1'b0;
        #1;
        chk("v037.cnt0", 64'(count), 64'd0);
        chk("v037.rdy0", 64'(op_ready), 64'd0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = NOP;
        reset    = 1'b1;
        chk("v037.cnt1", 64'(count), 64'd0);
        @(posedge clk);
        #1;
        view("v037", 64'd0, 64'd0, 0, 3'd0);
        apply(PUSH, 64'd21);
        view("post", 64'd21, 64'd0, 1, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
